// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack sequencer: op codes, FSM states, word width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stack_sequencer_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHECK = 4'd1,
    S_DEC   = 4'd2,
    S_WRITE = 4'd3,
    S_READ  = 4'd4,
    S_WAIT  = 4'd5,
    S_XFER  = 4'd6,
    S_INC   = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  // PUSH and CALL both write to the stack; they share op[0] == 0.
  function automatic logic is_push_like(input logic [1:0] op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/sp_register.sv
// Stack pointer register with pre-decrement/post-increment and full/empty compare.
// Latency: inc/dec take effect on the next clk edge; empty/full follow sp combinationally.
// Backpressure: none; the sequencer never asks for inc and dec together.
// Ports: clk, rst (sync, active-high), inc, dec -> sp, empty, full.
module sp_register import stack_sequencer_pkg::*; #(
  parameter logic [WORD_W-1:0] SP_RESET    = 16'hFFFF,
  parameter logic [WORD_W-1:0] STACK_LIMIT = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [WORD_W-1:0] sp,
  output logic              empty,
  output logic              full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= SP_RESET;
    end else if (dec) begin
      sp <= sp - WORD_W'(1);
    end else if (inc) begin
      sp <= sp + WORD_W'(1);
    end
  end

  assign empty = (sp == SP_RESET);
  assign full  = (sp == STACK_LIMIT);

endmodule

// File: rtl/stack_sequencer.sv
// Sequences bus, RAM and register-file strobes for PUSH/POP/CALL/RET using a private SP.
// Latency: start->done 4 (PUSH/CALL), READ_LATENCY+4 (POP/RET), 2 when rejected on full/empty.
// Backpressure: busy holds from the cycle after an accepted start through done; start is ignored outside IDLE.
// Ports: clk, rst, start/op/reg_sel request; busy/done/err status; rout/rin/pc_out_ctrl/pcin
//        bus strobes; ram_addr_sel/wren/ram_out_ctrl RAM strobes; sp_addr/empty/full stack state.
module stack_sequencer import stack_sequencer_pkg::*; #(
  parameter logic [WORD_W-1:0] SP_RESET     = 16'hFFFF,
  parameter logic [WORD_W-1:0] STACK_LIMIT  = 16'hFF00,
  parameter int                READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [2:0]        reg_sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        rout,
  output logic [7:0]        rin,
  output logic              pc_out_ctrl,
  output logic              pcin,
  output logic              ram_addr_sel,
  output logic              wren,
  output logic              ram_out_ctrl,
  output logic [WORD_W-1:0] sp_addr,
  output logic              empty,
  output logic              full
);

  // WAIT lasts READ_LATENCY-1 cycles; the counter is loaded with one less than that.
  localparam int         WAIT_INIT_I = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
  localparam logic [1:0] WAIT_INIT   = WAIT_INIT_I[1:0];

  state_t     state;
  logic [1:0] op_q;
  logic [2:0] reg_sel_q;
  logic [1:0] wait_cnt;
  logic       sp_inc;
  logic       sp_dec;

  assign sp_dec = (state == S_DEC);
  assign sp_inc = (state == S_INC);

  sp_register #(
    .SP_RESET    (SP_RESET),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk   (clk),
    .rst   (rst),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .sp    (sp_addr),
    .empty (empty),
    .full  (full)
  );

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

  // Outputs are registered: each transition also loads the strobes of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= OP_PUSH;
      reg_sel_q    <= '0;
      wait_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rout         <= '0;
      rin          <= '0;
      pc_out_ctrl  <= 1'b0;
      pcin         <= 1'b0;
      ram_addr_sel <= 1'b0;
      wren         <= 1'b0;
      ram_out_ctrl <= 1'b0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      rout         <= '0;
      rin          <= '0;
      pc_out_ctrl  <= 1'b0;
      pcin         <= 1'b0;
      ram_addr_sel <= 1'b0;
      wren         <= 1'b0;
      ram_out_ctrl <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q      <= op;
            reg_sel_q <= reg_sel;
            busy      <= 1'b1;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (is_push_like(op_q) ? full : empty) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (is_push_like(op_q)) begin
            state <= S_DEC;
          end else begin
            state        <= S_READ;
            ram_addr_sel <= 1'b1;
          end
        end
        S_DEC: begin
          state        <= S_WRITE;
          ram_addr_sel <= 1'b1;
          wren         <= 1'b1;
          if (op_q == OP_CALL) pc_out_ctrl <= 1'b1;
          else                 rout        <= onehot(reg_sel_q);
        end
        S_WRITE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_READ, S_WAIT: begin
          ram_addr_sel <= 1'b1;
          if (state == S_READ && READ_LATENCY > 1) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_INIT;
          end else if (state == S_WAIT && wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            state        <= S_XFER;
            ram_out_ctrl <= 1'b1;
            if (op_q == OP_RET) pcin <= 1'b1;
            else                rin  <= onehot(reg_sel_q);
          end
        end
        S_XFER: begin
          state <= S_INC;
        end
        S_INC: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: two instances (READ_LATENCY 1 and 2) driven in lock-step.
// The bench owns the register file, PC, bus and RAM around each instance and a stack-level model.
// Expected results come from the stack model: push/pop of values, SP = SP_RESET - depth.
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [2:0] reg_sel;

  logic        busy [N], done [N], err [N], pc_out_ctrl [N], pcin [N];
  logic        ram_addr_sel [N], wren [N], ram_out_ctrl [N], empty [N], full [N];
  logic [7:0]  rout [N], rin [N];
  logic [15:0] sp_addr [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    stack_sequencer #(
      .SP_RESET     (16'hFFFF),
      .STACK_LIMIT  (16'hFF00),
      .READ_LATENCY (g + 1)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .op           (op),
      .reg_sel      (reg_sel),
      .busy         (busy[g]),
      .done         (done[g]),
      .err          (err[g]),
      .rout         (rout[g]),
      .rin          (rin[g]),
      .pc_out_ctrl  (pc_out_ctrl[g]),
      .pcin         (pcin[g]),
      .ram_addr_sel (ram_addr_sel[g]),
      .wren         (wren[g]),
      .ram_out_ctrl (ram_out_ctrl[g]),
      .sp_addr      (sp_addr[g]),
      .empty        (empty[g]),
      .full         (full[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Environment around each instance.
  logic [15:0] regs  [N][8];
  logic [15:0] pc    [N];
  logic [15:0] ram   [N][256];
  logic [15:0] qpipe [N][3];

  // Reference model.
  logic [15:0] exp_regs [N][8];
  logic [15:0] exp_pc   [N];
  logic [15:0] stk [$];

  // Per-transaction observations.
  int          lat [N], n_wr [N], n_rd [N];
  bit          seen_done [N], got_err [N];
  logic [15:0] wr_addr [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] strobes(input int i);
    return {busy[i], done[i], err[i], rout[i], rin[i], pc_out_ctrl[i], pcin[i],
            ram_addr_sel[i], wren[i], ram_out_ctrl[i]};
  endfunction

  task automatic set_reg(input int k, input logic [15:0] v);
    for (int i = 0; i < N; i++) begin
      regs[i][k]     = v;
      exp_regs[i][k] = v;
    end
  endtask

  task automatic set_pc(input logic [15:0] v);
    for (int i = 0; i < N; i++) begin
      pc[i]     = v;
      exp_pc[i] = v;
    end
  endtask

  // Called once per cycle at the falling edge: checks strobes and applies the
  // bus/RAM/register effects that the following rising edge would commit.
  task automatic env_step(input logic [1:0] o, input logic [2:0] r, input bit active, input int cyc);
    for (int i = 0; i < N; i++) begin
      logic [15:0] bus;
      logic [15:0] addr;
      int          drv;
      bus = '0;
      drv = 0;
      for (int k = 0; k < 8; k++) if (rout[i][k]) begin bus |= regs[i][k]; drv++; end
      if (pc_out_ctrl[i])  begin bus |= pc[i];        drv++; end
      if (ram_out_ctrl[i]) begin bus |= qpipe[i][i];  drv++; end
      check($sformatf("bus_drivers[%0d]", i), drv <= 1, 1);
      addr = ram_addr_sel[i] ? sp_addr[i] : pc[i];
      if (wren[i]) begin
        n_wr[i]++;
        wr_addr[i] = sp_addr[i];
        check("wr_addr_sel", ram_addr_sel[i], 1);
        if (o == OP_CALL) check("wr_pc_out", {rout[i], pc_out_ctrl[i]}, 1);
        else              check("wr_rout", {rout[i], pc_out_ctrl[i]}, (8'b1 << r) << 1);
        ram[i][addr[7:0]] = bus;
      end else begin
        check("stray_drive", {rout[i], pc_out_ctrl[i]}, 0);
      end
      if (ram_out_ctrl[i]) begin
        n_rd[i]++;
        check("rd_addr_sel", ram_addr_sel[i], 1);
        if (o == OP_RET) check("rd_pcin", {rin[i], pcin[i]}, 1);
        else             check("rd_rin", {rin[i], pcin[i]}, (8'b1 << r) << 1);
      end else begin
        check("stray_load", {rin[i], pcin[i]}, 0);
      end
      for (int k = 0; k < 8; k++) if (rin[i][k]) regs[i][k] = bus;
      if (pcin[i]) pc[i] = bus;
      qpipe[i][2] = qpipe[i][1];
      qpipe[i][1] = qpipe[i][0];
      qpipe[i][0] = ram[i][addr[7:0]];
      if (active && !seen_done[i]) begin
        check("busy_in_op", busy[i], 1);
        if (done[i]) begin
          seen_done[i] = 1'b1;
          lat[i]       = cyc;
          got_err[i]   = err[i];
        end else begin
          check("err_without_done", err[i], 0);
        end
      end else begin
        check("idle_status", {busy[i], done[i], err[i]}, 0);
      end
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < N; i++) begin
      lat[i] = 0; n_wr[i] = 0; n_rd[i] = 0;
      seen_done[i] = 1'b0; got_err[i] = 1'b0; wr_addr[i] = '0;
    end
  endtask

  // Issues one request at a falling edge in IDLE; with hold, start stays high through DONE.
  task automatic run_op(input logic [1:0] o, input logic [2:0] r, input bit hold);
    int          cyc;
    int          exp_lat;
    bit          push_like;
    bit          rej;
    logic [15:0] v;
    push_like = (o == OP_PUSH) || (o == OP_CALL);
    rej = push_like ? (stk.size() == 255) : (stk.size() == 0);
    clear_obs();
    start = 1'b1; op = o; reg_sel = r;
    cyc = 0;
    while (!(seen_done[0] && seen_done[1]) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      env_step(o, r, 1'b1, cyc);
    end
    check("done_seen", {seen_done[0], seen_done[1]}, 2'b11);
    @(negedge clk);
    start = 1'b0;
    env_step(o, r, 1'b1, cyc + 1);
    if (!rej) begin
      if (push_like) begin
        stk.push_back((o == OP_CALL) ? exp_pc[0] : exp_regs[0][r]);
      end else begin
        v = stk.pop_back();
        for (int i = 0; i < N; i++) begin
          if (o == OP_RET) exp_pc[i] = v;
          else             exp_regs[i][r] = v;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_lat = rej ? 2 : (push_like ? 4 : (i + 1) + 4);
      check($sformatf("latency[%0d] op%0d", i, o), lat[i], exp_lat);
      check("err", got_err[i], rej);
      check("wren_cycles", n_wr[i], (push_like && !rej) ? 1 : 0);
      check("xfer_cycles", n_rd[i], (!push_like && !rej) ? 1 : 0);
      if (push_like && !rej) check("write_addr", wr_addr[i], 16'(32'hFFFF - stk.size()));
      check("sp_addr", sp_addr[i], 16'(32'hFFFF - stk.size()));
      check("empty", empty[i], stk.size() == 0);
      check("full", full[i], stk.size() == 255);
      check($sformatf("reg%0d", r), regs[i][r], exp_regs[i][r]);
      check("pc", pc[i], exp_pc[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    for (int i = 0; i < N; i++) begin
      check("rst_strobes", strobes(i), 0);
      check("rst_sp", sp_addr[i], 16'hFFFF);
      check("rst_empty_full", {empty[i], full[i]}, 2'b10);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      env_step(OP_PUSH, 3'd0, 1'b0, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = OP_PUSH; reg_sel = 3'd0;
    for (int i = 0; i < N; i++) begin
      for (int a = 0; a < 256; a++) ram[i][a] = '0;
      for (int s = 0; s < 3; s++) qpipe[i][s] = '0;
    end
    for (int k = 0; k < 8; k++) set_reg(k, 16'($urandom));
    set_pc(16'h0100);
    do_reset();

    // Directed push/pop round trip and empty rejection.
    set_reg(2, 16'h1234);
    run_op(OP_PUSH, 3'd2, 1'b0);
    run_op(OP_POP, 3'd5, 1'b0);
    check("r6_after_pop", regs[0][5], 16'h1234);
    run_op(OP_POP, 3'd1, 1'b0);

    // Randomized mix of operations, register contents and idle gaps.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) set_reg($urandom_range(0, 7), 16'($urandom));
      if ($urandom_range(0, 4) == 0) set_pc(16'($urandom));
      run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0);
      idle($urandom_range(0, 2));
    end

    // start held high for the whole transaction must not launch a second one.
    run_op(OP_PUSH, 3'd7, 1'b1);
    idle(2);

    // Fill to the limit, then one more push is rejected.
    do_reset();
    while (stk.size() < 255) begin
      set_reg(0, 16'($urandom));
      run_op(OP_PUSH, 3'($urandom_range(0, 7)), 1'b0);
    end
    check("full_sp", sp_addr[1], 16'hFF00);
    run_op(OP_PUSH, 3'd3, 1'b0);

    // CALL/RET round trip of the PC.
    repeat (3) run_op(OP_POP, 3'($urandom_range(0, 7)), 1'b0);
    set_pc(16'h0040);
    run_op(OP_CALL, 3'd0, 1'b0);
    set_pc(16'h1357);
    run_op(OP_RET, 3'd0, 1'b0);
    check("pc_restored", pc[1], 16'h0040);

    // Reset during WAIT of a POP (instance with READ_LATENCY 2).
    do_reset();
    set_reg(1, 16'hBEEF);
    run_op(OP_PUSH, 3'd1, 1'b0);
    clear_obs();
    start = 1'b1; op = OP_POP; reg_sel = 3'd4;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      env_step(OP_POP, 3'd4, 1'b1, c);
    end
    check("abort_in_wait", {ram_addr_sel[1], ram_out_ctrl[1]}, 2'b10);
    check("abort_inst0_xfer", ram_out_ctrl[0], 1);
    // Instance 0 is already transferring in this cycle, so its register load completes.
    exp_regs[0][4] = stk[stk.size() - 1];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("abort_strobes", strobes(i), 0);
      check("abort_sp", sp_addr[i], 16'hFFFF);
      check("abort_empty", empty[i], 1);
      check("abort_reg", regs[i][4], exp_regs[i][4]);
    end
    stk.delete();
    env_step(OP_PUSH, 3'd0, 1'b0, 0);
    idle(3);
    run_op(OP_POP, 3'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Multi-cycle controller that sequences the shared bus, RAM and register file to perform PUSH, POP, CALL and RET.
- Owns a dedicated 16-bit stack pointer (SP) and drives the RAM address-select, write-enable and tri-state output-enable strobes for one stack transaction at a time.
- Sits beside the control unit. The control unit raises start with an opcode and register index, then stalls on busy until done.
- Frees the datapath from hard-wired RAM write-disable and from using r8 as the stack pointer.

Parameters:
- SP_RESET, 16'hFFFF, SP value after reset; stack is empty when SP equals this value.
- STACK_LIMIT, 16'hFF00, lowest writable stack address; stack is full when SP equals this value.
- READ_LATENCY, 1, clock cycles from RAM address valid to q valid; legal values 1..3.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request, sampled only in IDLE
- op  in  2  operation: 00 PUSH, 01 POP, 10 CALL, 11 RET; latched on accepted start
- reg_sel  in  3  register index 0..7 (r1..r8); latched on accepted start
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse when the transaction completes or is rejected
- err  out  1  one-cycle pulse with done: PUSH/CALL when full, or POP/RET when empty
- rout  out  8  one-hot register-to-bus enable
- rin  out  8  one-hot bus-to-register load enable
- pc_out_ctrl  out  1  PC drives the bus
- pcin  out  1  PC loads from the bus
- ram_addr_sel  out  1  1 selects sp_addr as RAM address, 0 selects PC
- wren  out  1  RAM write enable
- ram_out_ctrl  out  1  RAM q drives the bus
- sp_addr  out  16  current SP
- empty  out  1  SP == SP_RESET
- full  out  1  SP == STACK_LIMIT

Behaviour:
- Reset is synchronous and active-high: on a clk edge with rst=1, state goes to IDLE and SP to SP_RESET. All strobes, busy, done and err are 0 from that edge. Reset aborts any in-flight operation; no partial SP update is kept.
- All outputs are Moore, decoded from state and latched fields only. There is no combinational path from start, op or reg_sel to any output.
- At most one bus-driving strobe (rout, pc_out_ctrl, ram_out_ctrl) is active in any cycle.
- States: IDLE, CHECK, DEC, WRITE, READ, WAIT, XFER, INC, DONE.
- IDLE:
  - start=1 latches op and reg_sel, then goes to CHECK.
  - start while busy is ignored and is not queued.
- CHECK:
  - PUSH/CALL with full=1, or POP/RET with empty=1: go to DONE with err set. SP and RAM are untouched.
  - PUSH/CALL otherwise: go to DEC.
  - POP/RET otherwise: go to READ.
- DEC: SP <= SP-1 (pre-decrement), then go to WRITE.
- WRITE (1 cycle): ram_addr_sel=1 and wren=1.
  - PUSH: rout[reg_sel]=1.
  - CALL: pc_out_ctrl=1.
  - Then go to DONE.
- READ: ram_addr_sel=1, then go to WAIT.
- WAIT: ram_addr_sel=1 held for READ_LATENCY-1 cycles using a 2-bit counter. With READ_LATENCY=1 this state is skipped and READ goes straight to XFER.
- XFER (1 cycle): ram_addr_sel=1 and ram_out_ctrl=1.
  - POP: rin[reg_sel]=1.
  - RET: pcin=1.
  - Then go to INC.
- INC: SP <= SP+1, then go to DONE.
- DONE: done=1, and err=1 only if the transaction was rejected in CHECK. Next state is IDLE.
- Latency from start to done, with READ_LATENCY=1:
  - PUSH/CALL: 4 cycles.
  - POP/RET: READ_LATENCY+4 cycles.
  - Rejected: 2 cycles.
- SP arithmetic is 16-bit. Wrap-around cannot occur because full and empty are checked first.
- reg_sel=7 (r8) is an ordinary register with no stack meaning.
- start asserted in the DONE cycle is ignored. The earliest accepted start is in the following IDLE cycle.

Decomposition:
- Shared package holds:
  - op encodings OP_PUSH, OP_POP, OP_CALL, OP_RET;
  - state encoding constants;
  - the 16-bit word width constant.
- One natural sub-module: sp_register, holding the 16-bit SP with load-reset, inc and dec, plus full/empty compare.
- The FSM and the output decode stay in stack_sequencer.

Test Plan:
- Reset, then PUSH reg_sel=2 with r3=16'h1234 (testbench drives the bus model) -> WRITE cycle at sp_addr=16'hFFFE with wren=1 and rout=8'b00000100; done 4 cycles after start; SP=16'hFFFE; empty=0.
- Follow with POP reg_sel=5 -> XFER with ram_out_ctrl=1 and rin=8'b00100000; r6=16'h1234; SP=16'hFFFF; empty=1; done after 5 cycles.
- POP when empty -> done and err after 2 cycles; no rin, ram_out_ctrl or wren; SP remains 16'hFFFF.
- 255 PUSHes -> full=1 with SP=16'hFF00; 256th PUSH -> err=1, no wren, SP unchanged.
- CALL with PC=16'h0040, then RET, with READ_LATENCY=2 -> pc_out_ctrl during WRITE, pcin during XFER; PC restored to 16'h0040; RET done after 6 cycles.
- rst asserted in WAIT of a POP -> next cycle: IDLE, SP=16'hFFFF, all strobes 0, no done; start held high while busy -> no second transaction.
